// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide engine.
package mul_div_unit_pkg;

  // Operation encodings presented on op with start.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Controller states; StMul is reserved and never entered by the current datapath.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMul    = 2'b01,
    StDivRun = 2'b10,
    StDone   = 2'b11
  } md_state_e;

  // Two's-complement negate when cond is set.
  function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] val);
    return cond ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/mul_div_unit_div.sv
// Radix-2 restoring divider: loads magnitudes on start_i, one step per enabled
// cycle, and presents the sign-corrected {rem, quo} of the current step on done_o.
module mul_div_unit_div
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DivSteps = 32
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        en_i,
  output logic        done_o,
  output logic [63:0] result_o
);

  localparam int unsigned CntW = (DivSteps > 1) ? $clog2(DivSteps) : 1;

  logic [31:0]     rem_q, quo_q, dvs_q;
  logic            neg_quo_q, neg_rem_q;
  logic [CntW-1:0] cnt_q;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_step, quo_step;

  // One restoring step: shift the pair left, trial-subtract, keep if non-negative.
  // The partial remainder needs 33 bits because an unsigned divisor may exceed 2^31.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = (shifted >= {1'b0, dvs_q});
    rem_step = fits ? diff[31:0] : shifted[31:0];
    quo_step = {quo_q[30:0], fits};
  end

  // Final step result with sign fix-up applied; only consumed when done_o is high.
  always_comb begin
    done_o   = en_i && (cnt_q == CntW'(DivSteps - 1));
    result_o = {neg_if(neg_rem_q, rem_step), neg_if(neg_quo_q, quo_step)};
  end

  // Operand load and iteration state.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start_i) begin
      rem_q     <= '0;
      quo_q     <= neg_if(signed_i & dividend_i[31], dividend_i);
      dvs_q     <= neg_if(signed_i & divisor_i[31], divisor_i);
      neg_quo_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
      neg_rem_q <= signed_i & dividend_i[31];
      cnt_q     <= '0;
    end else if (en_i) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU engine producing {hi, lo} and a one-cycle write pulse.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic        stall_o,
  output logic        busy,
  output logic [63:0] hilo_o,
  output logic        hilo_we
);

  md_state_e   state_q, state_d;
  logic [63:0] hilo_q, hilo_d;

  logic        issue;
  logic        is_div;
  logic        b_zero;
  logic        div_start;
  logic        div_en;
  logic        div_done;
  logic [63:0] div_result;
  logic [63:0] prod_s, prod_u;

  assign issue     = (state_q == StIdle) && start && !annul;
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign b_zero    = (src_b == 32'd0);
  assign div_start = issue && is_div && !b_zero;
  assign div_en    = (state_q == StDivRun);

  // Full-width products; sign-extending to 64 bits keeps the low 64 bits exact.
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  mul_div_unit_div #(
    .DivSteps(DIV_STEPS)
  ) u_div (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .start_i   (div_start),
    .signed_i  (op == MD_DIV),
    .dividend_i(src_a),
    .divisor_i (src_b),
    .en_i      (div_en),
    .done_o    (div_done),
    .result_o  (div_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul aborts every busy state except DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = (is_div && !b_zero) ? StDivRun : StDone;
        end
      end
      StMul:    state_d = annul ? StIdle : StDone;
      StDivRun: begin
        if (annul) begin
          state_d = StIdle;
        end else if (div_done) begin
          state_d = StDone;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Result register loads only on the edge that enters DONE.
  always_comb begin
    hilo_d = hilo_q;
    if (issue) begin
      case (op)
        MD_MULT:  hilo_d = prod_s;
        MD_MULTU: hilo_d = prod_u;
        default:  if (b_zero) hilo_d = {src_a, 32'hFFFF_FFFF};
      endcase
    end else if ((state_q == StDivRun) && !annul && div_done) begin
      hilo_d = div_result;
    end
  end

  // Result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  // Outputs; stall drops in DONE so the issuing instruction advances with the result.
  always_comb begin
    stall_o = issue || (state_q == StMul) || (state_q == StDivRun);
    busy    = (state_q != StIdle);
    hilo_we = (state_q == StDone);
    hilo_o  = hilo_q;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Execute-stage multiply/divide engine for MULT, MULTU, DIV and DIVU.
- Produces the 64-bit {hi, lo} result plus a one-cycle write-enable, consumed by the downstream HI/LO register in MEM.
- Multiplies complete in one clock; divides are iterative radix-2 restoring.
- The stall request holds the pipeline until the result is ready.

Parameters:
- DIV_STEPS, 32: number of restoring iterations; equals the operand width.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  reset; **synchronous and active-low**, sampled on the rising clk edge.
- start  input  1  issue request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
- src_a  input  32  rs operand (dividend or multiplicand).
- src_b  input  32  rt operand (divisor or multiplier).
- annul  input  1  flush; abandons any in-flight operation.
- stall_o  output  1  pipeline hold request.
- busy  output  1  state is not IDLE.
- hilo_o  output  64  {hi, lo} result; held stable between completions.
- hilo_we  output  1  one-cycle pulse while hilo_o is valid for writing.

Behaviour:
- Reset (resetn=0 at an edge): state IDLE, hilo_o=0, hilo_we=0, busy=0, iteration counter=0, internal registers cleared. Reset mid-operation aborts with no hilo_we.
- States: IDLE, MUL, DIV_RUN, DONE.
- IDLE with start=1 and annul=0, by op:
  - MULT/MULTU: product registered at this edge; next state DONE (MUL is passed through in zero cycles; the encoding is reserved).
  - DIV/DIVU with src_b != 0: load |a| and |b| (raw values for DIVU) and the two sign flags; counter=0; next state DIV_RUN.
  - DIV/DIVU with src_b == 0: hilo_o={src_a, 32'hFFFFFFFF}; next state DONE.
- DIV_RUN: one restoring step per edge.
  - Remainder:quotient pair shifted left 1; trial subtract the divisor; the quotient bit is set if the result is non-negative.
  - Counter increments each step. After step DIV_STEPS (counter reaches 31 then wraps), apply the sign fix and go to DONE.
- Sign rules:
  - Quotient is negated iff the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- MULT is a signed 32x32 product and MULTU unsigned, both full 64 bits; hi = upper word.
- DONE: hilo_we=1 for exactly this cycle, then unconditionally return to IDLE.
- stall_o = (state==IDLE & start & ~annul) | state==MUL | state==DIV_RUN. It is 0 in DONE, so the issuing instruction advances with the result.
- Latency from the start edge to the hilo_we cycle:
  - MULT/MULTU and divide-by-zero: 1 cycle.
  - DIV/DIVU: DIV_STEPS+1 = 33 cycles.
- start is ignored unless the state is IDLE. A start in the DONE cycle is not accepted; the pipeline re-presents it, since stall_o was low.
- annul=1 in any non-IDLE state: next state IDLE, hilo_we stays 0, hilo_o keeps its old value.
- annul=1 in IDLE overrides start.
- annul in the DONE cycle has no effect: the write already occurs in this cycle, and commit gating is the MEM stage's concern.
- hilo_o changes only on entry to DONE.

Decomposition:
- Shared defines header: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and state encodings.
- Natural sub-module: div_core (restoring iterator with sign pre/post handling, start/done interface).
- The multiply path and the FSM stay in mul_div_unit.

Test Plan:
1. MULT a=0xFFFFFFFE (-2), b=3 -> 1 cycle later hilo_we=1, hilo_o=0xFFFFFFFF_FFFFFFFA; stall_o high only in the start cycle.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hilo_o=0xFFFFFFFE_00000001.
3. DIV a=-7 (0xFFFFFFF9), b=2 -> stall_o high 33 cycles; hilo_we on cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFD.
4. DIVU a=100, b=7 -> hi=2, lo=14; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. DIV b=0, a=0x12345678 -> 1-cycle completion, hilo_o=0x12345678_FFFFFFFF.
6. Start DIV 100/7, then:
   - annul at cycle 10 -> IDLE next cycle, no hilo_we, hilo_o unchanged.
   - In a separate run, resetn=0 at cycle 5 -> all outputs 0.
   - start pulses during DIV_RUN are ignored.
